// File: rtl/ov7670_stream_source.sv
// ov7670_stream_source: emulates the OV7670 DVP output pins (pclk, vsync,
// href, d[7:0]) with sensor-accurate timing and deterministic test patterns.
// ov_pclk runs at clk/2. All frame timing and data advance on the clk edge
// where ov_pclk falls, so a capture block sees stable data on pclk rising.
// Optional feature: define OV7670_SRC_FRAME_STAMP_EN to overwrite bytes 0
// and 1 of the first active line with frame_cnt (low byte, then high byte).
module ov7670_stream_source #(
    parameter int H_ACTIVE     = 640,
    parameter int BPP          = 2,
    parameter int H_BLANK      = 288,
    parameter int V_SYNC_LINES = 3,
    parameter int V_BACK       = 17,
    parameter int V_ACTIVE     = 480,
    parameter int V_FRONT      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [7:0]  const_val,
    output logic        ov_pclk,
    output logic        ov_vsync,
    output logic        ov_href,
    output logic [7:0]  ov_d,
    output logic [15:0] frame_cnt,
    output logic        frame_start,
    output logic        busy
);

    localparam int H_PIX_BYTES = H_ACTIVE * BPP;
    localparam int LINE_T      = H_PIX_BYTES + H_BLANK;
    localparam int HW          = (LINE_T > 1) ? $clog2(LINE_T) : 1;
    localparam int V_MAX_A     = (V_SYNC_LINES > V_BACK) ? V_SYNC_LINES : V_BACK;
    localparam int V_MAX_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX       = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int VW          = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    // First region with a non-zero line count at or after s; IDLE if none.
    function automatic state_t first_from(input state_t s);
        state_t r;
        case (s)
            VSYNC:   r = (V_SYNC_LINES > 0) ? VSYNC :
                         (V_BACK > 0)       ? VBACK :
                         (V_ACTIVE > 0)     ? ACTIVE :
                         (V_FRONT > 0)      ? VFRONT : IDLE;
            VBACK:   r = (V_BACK > 0)       ? VBACK :
                         (V_ACTIVE > 0)     ? ACTIVE :
                         (V_FRONT > 0)      ? VFRONT : IDLE;
            ACTIVE:  r = (V_ACTIVE > 0)     ? ACTIVE :
                         (V_FRONT > 0)      ? VFRONT : IDLE;
            VFRONT:  r = (V_FRONT > 0)      ? VFRONT : IDLE;
            default: r = IDLE;
        endcase
        return r;
    endfunction

    // Region following s, skipping empty ones; IDLE marks the frame end.
    function automatic state_t next_region(input state_t s);
        state_t r;
        case (s)
            VSYNC:   r = first_from(VBACK);
            VBACK:   r = first_from(ACTIVE);
            ACTIVE:  r = first_from(VFRONT);
            default: r = IDLE;
        endcase
        return r;
    endfunction

    function automatic int lines_of(input state_t s);
        int n;
        case (s)
            VSYNC:   n = V_SYNC_LINES;
            VBACK:   n = V_BACK;
            ACTIVE:  n = V_ACTIVE;
            VFRONT:  n = V_FRONT;
            default: n = 0;
        endcase
        return n;
    endfunction

    localparam state_t FIRST = first_from(VSYNC);

    state_t          state, state_nx;
    logic [HW-1:0]   h_cnt, h_nx;
    logic [VW-1:0]   v_cnt, v_nx;
    logic [1:0]      mode_q, mode_nx;
    logic [15:0]     fc_nx;
    logic            tick;
    logic            h_wrap;
    logic            start;
    logic            frame_end;
    logic            href_nx;
    logic [7:0]      px_x, px_y;
    logic [7:0]      pat;
    logic [7:0]      d_nx;

    // ov_pclk is about to fall on this clk edge.
    assign tick = ov_pclk;

    // Next-state, counter and output-value computation for the coming tick.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nx  = state;
        h_nx      = h_cnt;
        v_nx      = v_cnt;
        mode_nx   = mode_q;
        h_wrap    = 1'b0;
        start     = 1'b0;
        frame_end = 1'b0;

        if (state == IDLE) begin
            start = en;
        end else begin
            h_wrap = (int'(h_cnt) == LINE_T - 1);
            h_nx   = h_wrap ? '0 : h_cnt + HW'(1);
            if (h_wrap) begin
                if (int'(v_cnt) == lines_of(state) - 1) begin
                    v_nx     = '0;
                    state_nx = next_region(state);
                    if (state_nx == IDLE) begin
                        frame_end = 1'b1;
                        start     = en;
                    end
                end else begin
                    v_nx = v_cnt + VW'(1);
                end
            end
        end

        if (start) begin
            state_nx = FIRST;
            h_nx     = '0;
            v_nx     = '0;
            mode_nx  = mode;
        end

        fc_nx   = frame_cnt + {15'd0, frame_end};
        href_nx = (state_nx == ACTIVE) && (int'(h_nx) < H_PIX_BYTES);
        px_x    = 8'(int'(h_nx) / BPP);
        px_y    = 8'(v_nx);

        case (mode_nx)
            2'd0:    pat = px_x;
            2'd1:    pat = px_y;
            2'd2:    pat = (px_x[3] ^ px_y[3]) ? 8'hFF : 8'h00;
            default: pat = const_val;
        endcase

`ifdef OV7670_SRC_FRAME_STAMP_EN
        // Frame stamp: first two bytes of active line 0 carry frame_cnt.
        if (state_nx == ACTIVE && v_nx == '0) begin
            if (h_nx == HW'(0)) pat = fc_nx[7:0];
            if (h_nx == HW'(1)) pat = fc_nx[15:8];
        end
`endif

        d_nx = href_nx ? pat : 8'h00;
    end

    // State, counters and pin registers: pclk every clk, the rest on ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            mode_q      <= 2'd0;
            ov_pclk     <= 1'b0;
            ov_vsync    <= 1'b0;
            ov_href     <= 1'b0;
            ov_d        <= 8'h00;
            frame_cnt   <= 16'h0000;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            ov_pclk     <= ~ov_pclk;
            frame_start <= 1'b0;
            if (tick) begin
                state       <= state_nx;
                h_cnt       <= h_nx;
                v_cnt       <= v_nx;
                mode_q      <= mode_nx;
                frame_cnt   <= fc_nx;
                frame_start <= start;
                ov_vsync    <= (state_nx == VSYNC);
                ov_href     <= href_nx;
                ov_d        <= d_nx;
                busy        <= (state_nx != IDLE);
            end
        end
    end

endmodule

// File: tb/tb_ov7670_stream_source.sv
// tb_ov7670_stream_source: directed self-checking bench for the OV7670 pin
// emulator, using a reduced geometry (12 pclk lines, 72 pclk frames).
module tb_ov7670_stream_source;

    localparam int LT      = 12;  // pclks per line
    localparam int FRAME_P = 72;  // pclks per frame
    localparam int ACT_B   = 8;   // href-high pclks per line

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [7:0]  const_val;
    logic        ov_pclk;
    logic        ov_vsync;
    logic        ov_href;
    logic [7:0]  ov_d;
    logic [15:0] frame_cnt;
    logic        frame_start;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    ov7670_stream_source #(
        .H_ACTIVE     (4),
        .BPP          (2),
        .H_BLANK      (4),
        .V_SYNC_LINES (1),
        .V_BACK       (1),
        .V_ACTIVE     (3),
        .V_FRONT      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .const_val   (const_val),
        .ov_pclk     (ov_pclk),
        .ov_vsync    (ov_vsync),
        .ov_href     (ov_href),
        .ov_d        (ov_d),
        .frame_cnt   (frame_cnt),
        .frame_start (frame_start),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    task automatic check(input string tag, input int p, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s p=%0d: observed %0h expected %0h", tag, p, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next clk edge where ov_pclk falls.
    task automatic next_tick();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ov_pclk === 1'b0) return;
        end
        n_cmp++;
        n_fail++;
        $error("FAIL pclk_timeout: observed no falling pclk in 4 clk, required one");
        summary();
        $finish;
    endtask

    // Reference data byte at pclk p of a frame.
    function automatic logic [7:0] exp_d(input logic [1:0] m, input logic [7:0] cv,
                                         input int p, input logic [15:0] fc);
        int line;
        int h;
        logic [7:0] x;
        logic [7:0] y;
        line = p / LT;
        h    = p % LT;
        if (line < 2 || line > 4 || h >= ACT_B) return 8'h00;
        x = 8'(h / 2);
        y = 8'(line - 2);
`ifdef OV7670_SRC_FRAME_STAMP_EN
        if (y == 8'd0 && h == 0) return fc[7:0];
        if (y == 8'd0 && h == 1) return fc[15:8];
`endif
        case (m)
            2'd0:    return x;
            2'd1:    return y;
            2'd2:    return (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            default: return cv;
        endcase
    endfunction

    // Check one full frame, starting with the tick that begins it.
    task automatic run_frame(input logic [1:0] m, input logic [7:0] cv,
                             input logic [15:0] fc, input int chg_at, input int drop_at);
        for (int p = 0; p < FRAME_P; p++) begin
            int line;
            logic href_e;
            next_tick();
            line   = p / LT;
            href_e = (line >= 2 && line <= 4 && (p % LT) < ACT_B);
            check("vsync", p, 16'(ov_vsync), 16'(p < LT));
            check("href",  p, 16'(ov_href),  16'(href_e));
            check("d",     p, 16'(ov_d),     16'(exp_d(m, cv, p, fc)));
            check("busy",  p, 16'(busy),     16'd1);
            check("frame_start", p, 16'(frame_start), 16'(p == 0));
            check("frame_cnt",   p, frame_cnt, fc);
            if (p == 0) begin
                @(posedge clk);
                #1;
                check("frame_start_width", p, 16'(frame_start), 16'd0);
            end
            if (p == chg_at)  mode = 2'd0;
            if (p == drop_at) en   = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        mode      = 2'd0;
        const_val = 8'h00;

        // Reset values.
        #20;
        check("rst_pclk",  0, 16'(ov_pclk),  16'd0);
        check("rst_vsync", 0, 16'(ov_vsync), 16'd0);
        check("rst_href",  0, 16'(ov_href),  16'd0);
        check("rst_d",     0, 16'(ov_d),     16'd0);
        check("rst_fcnt",  0, frame_cnt,     16'd0);
        check("rst_fs",    0, 16'(frame_start), 16'd0);
        check("rst_busy",  0, 16'(busy),     16'd0);

        // Idle with en low: nothing starts.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_tick();
            check("idle_vsync", i, 16'(ov_vsync), 16'd0);
            check("idle_busy",  i, 16'(busy),     16'd0);
        end

        // Back-to-back frames: ramp, then line index.
        en = 1'b1;
        run_frame(2'd0, 8'h00, 16'd0, -1, -1);
        mode = 2'd1;
        run_frame(2'd1, 8'h00, 16'd1, -1, -1);

        // Constant mode; mode changes mid-frame take effect next frame.
        mode      = 2'd3;
        const_val = 8'hA5;
        run_frame(2'd3, 8'hA5, 16'd2, 20, -1);
        run_frame(2'd0, 8'hA5, 16'd3, -1, -1);

        // en dropped at pclk 30: the frame completes, then idle.
        run_frame(2'd0, 8'hA5, 16'd4, -1, 30);
        next_tick();
        check("stop_vsync", 0, 16'(ov_vsync), 16'd0);
        check("stop_busy",  0, 16'(busy),     16'd0);
        check("stop_fcnt",  0, frame_cnt,     16'd5);
        check("stop_fs",    0, 16'(frame_start), 16'd0);
        for (int i = 1; i < 4; i++) begin
            next_tick();
            check("stop_idle_vsync", i, 16'(ov_vsync), 16'd0);
            check("stop_idle_href",  i, 16'(ov_href),  16'd0);
        end
        en = 1'b1;
        run_frame(2'd0, 8'hA5, 16'd5, -1, -1);

        // Reset asserted mid-ACTIVE while pclk is high.
        mode = 2'd3;
        for (int p = 0; p < 30; p++) next_tick();
        @(posedge clk);
        #1;
        check("pre_rst_pclk", 29, 16'(ov_pclk), 16'd1);
        check("pre_rst_href", 29, 16'(ov_href), 16'd1);
        check("pre_rst_d",    29, 16'(ov_d),    16'hA5);
        check("pre_rst_fcnt", 29, frame_cnt,    16'd6);
        rst_n = 1'b0;
        #1;
        check("async_pclk",  0, 16'(ov_pclk),  16'd0);
        check("async_vsync", 0, 16'(ov_vsync), 16'd0);
        check("async_href",  0, 16'(ov_href),  16'd0);
        check("async_d",     0, 16'(ov_d),     16'd0);
        check("async_fcnt",  0, frame_cnt,     16'd0);
        check("async_busy",  0, 16'(busy),     16'd0);
        @(negedge clk);
        mode  = 2'd0;
        rst_n = 1'b1;
        run_frame(2'd0, 8'hA5, 16'd0, -1, -1);

        // Run up to frame_cnt 0x0102, then check the stamped frame.
        for (int i = 0; i < 257 * FRAME_P; i++) next_tick();
        check("ffwd_fcnt", 0, frame_cnt, 16'h0101);
        run_frame(2'd0, 8'hA5, 16'h0102, -1, -1);

        summary();
        $finish;
    end

endmodule
